d_cache_nway: RTL and testbench
===============================

# d_cache_nway

Parametrised write-back, write-allocate, N-way set-associative data cache with multi-word lines and tree pseudo-LRU replacement. It sits between the MIPS core data port and the AXI bridge's sram-like data port, replacing the fixed 4-way, one-word-line data cache. It adds:
- burst refill and write-back of whole lines, one word per lower transaction;
- an uncached bypass mode for kseg1/MMIO accesses.

## Interface
Parameters:
- INDEX_WIDTH, 6: set index bits; SETS = 2^INDEX_WIDTH.
- LINE_WORDS, 4: 32-bit words per line; power of 2, range 1..16.
- WAYS, 4: associativity; power of 2, range 2..8.
- TAG_WIDTH, derived: 32 - INDEX_WIDTH - log2(LINE_WORDS) - 2.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- rst  in  1  reset, synchronous, active-high.
- cpu_data_req  in  1  core request; held stable until cpu_data_addr_ok.
- cpu_data_wr  in  1  1 = store.
- cpu_data_size  in  2  00 = byte, 01 = half, 10 = word.
- cpu_data_addr  in  32  byte address.
- cpu_data_wdata  in  32  store data, byte-lane aligned.
- cpu_data_uncached  in  1  1 = bypass the cache arrays.
- cpu_data_rdata  out  32  load data.
- cpu_data_addr_ok  out  1  request accepted.
- cpu_data_data_ok  out  1  load data valid / store complete.
- cache_data_req  out  1  lower request.
- cache_data_wr  out  1  lower write.
- cache_data_size  out  2  lower size.
- cache_data_addr  out  32  lower address.
- cache_data_wdata  out  32  lower write data.
- cache_data_rdata  in  32  lower read data.
- cache_data_addr_ok  in  1  lower address accepted.
- cache_data_data_ok  in  1  lower data done.

## Operation
- Address split: {tag, index, word, 2'b00}.
- Per set and way: valid, dirty, tag, LINE_WORDS data words. Per set: WAYS-1 pLRU tree bits.
- Hit: valid way with matching tag, and cpu_data_uncached = 0.
  - Load returns the addressed word.
  - Store merges the byte mask (from size and addr[1:0]) into the word and sets dirty.
- Victim selection: the lowest-index invalid way; if every way is valid, the pLRU tree victim.
- pLRU tree:
  - A node bit of 0 points to the lower-index subtree, 1 to the upper.
  - Victim = follow the pointers down from the root.
  - On a hit, or on refill completion, every node on the accessed way's path is set to point away from that way.
- FSM states: IDLE, WB, RF, UNC.
  - IDLE, cached miss with a dirty victim → WB.
  - IDLE, cached miss with a clean victim → RF.
  - IDLE with cpu_data_uncached = 1 → UNC.
  - WB: LINE_WORDS lower writes to {victim_tag, index, k, 2'b00} for k = 0..LINE_WORDS-1, size 10; then → RF.
  - RF: LINE_WORDS lower reads to {tag, index, k, 2'b00}, size 10. Each word is written into the victim way as it arrives. After the last word: valid = 1, dirty = 0, tag written, pLRU updated; then → IDLE.
  - UNC: one lower transaction with the core's wr, size, addr and wdata. cpu_data_addr_ok follows cache_data_addr_ok; cpu_data_data_ok and rdata follow the lower side. Arrays are untouched. → IDLE on cache_data_data_ok.
- Misses are write-allocate. After RF returns to IDLE, the still-held request hits and completes; no merge during refill.
- No coherence is kept between uncached accesses and cached copies.

## Timing
- Reset values: all cpu_* and cache_* outputs 0; state = IDLE; all valid, dirty and pLRU bits 0; word counter 0; outstanding flag 0. Tag and data arrays are not reset.
- Hit: cpu_data_addr_ok, cpu_data_data_ok and rdata are combinational in the request cycle. Array and pLRU updates happen at the next posedge.
- Lower side has at most one transaction outstanding:
  - cache_data_req is high in WB, RF and UNC only while no transaction is outstanding.
  - The outstanding flag sets on req & addr_ok and clears on data_ok.
  - The word counter advances on data_ok and wraps to 0 at the end of each WB and RF.
- Clean miss latency: LINE_WORDS lower transactions, then the hit cycle. A dirty miss adds LINE_WORDS write transactions.
- A request is never accepted outside IDLE; cpu_data_addr_ok = 0 there except in UNC.
- Mid-operation rst: → IDLE and all lines invalid on that edge. A partially filled line is never valid. Any lower transaction in flight is abandoned; the bridge is reset together with this block.

## Structure
- Package d_cache_pkg holds:
  - the state enum {IDLE, WB, RF, UNC};
  - the size encodings;
  - the byte-mask function;
  - log2 helper localparams.
- Sub-module plru_tree (parameter WAYS): combinational victim output, plus a next-bits function taking the accessed way. It is instanced once per lookup on the indexed set's bits.

## Test plan
All scenarios use defaults (INDEX_WIDTH 6, LINE_WORDS 4, WAYS 4); index = addr[9:4].
1. Cold load 0x0000_1040 → lower reads 0x1040, 0x1044, 0x1048, 0x104C in order, then data_ok with mem[0x1040]. Load 0x104C next → hit in the request cycle, no lower request.
2. Line from 1 resident, mem[0x1040] = 0x11223344; sb 0xAB to 0x1041 → immediate data_ok; a load of 0x1040 returns 0x1122AB44; the line is dirty.
3. Load tags at 0x0040, 0x0440, 0x0840, 0x0C40 (set 4), store to 0x0040, then touch 0x0440, 0x0840, 0x0C40; load 0x1040 → 4 writes to 0x0040..0x004C (store data present), then 4 reads 0x1040..0x104C.
4. Hits to ways 0, 1, 2, 3, 0 of one full set, then a miss → way 2 refilled.
5. Uncached load 0xBFC0_0000, size 00 → exactly one lower read with size 00 and that address; rdata passed through; a repeat access issues the lower read again.
6. rst pulsed after 2 of 4 refill words → IDLE, outputs 0; re-requesting the same address performs a full 4-word refill.

Source files
------------

// File: rtl/d_cache_pkg.sv
// d_cache_pkg
// Shared definitions for the N-way data cache: controller states, lower-side
// size encodings, store byte-mask helpers and small width helpers.
package d_cache_pkg;

  // Controller states: idle/lookup, write-back, refill, uncached pass-through.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RF   = 2'd2,
    UNC  = 2'd3
  } state_t;

  // Access size encodings shared by the core and lower ports.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte offset bits inside a 32-bit word.
  localparam int BYTE_OFFSET_BITS = 2;

  // Bit width able to index n items, never less than 1 so that
  // single-entry fields still get a legal vector.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  // The unused 2'b11 encoding is treated as a full word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << offset;
      SIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Widen a byte-lane mask into a 32-bit bit mask.
  function automatic logic [31:0] expand_mask(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/d_cache_plru_tree.sv
// plru_tree
// Tree pseudo-LRU for one set. Node bits are stored heap-style: node 0 is the
// root, node n has children 2n+1 (lower-index half) and 2n+2 (upper half).
// A node bit of 0 points at the lower subtree, 1 at the upper subtree.
// Ports:
//   bits       in   current WAYS-1 tree bits of the set
//   access_way in   way being hit or refilled
//   victim     out  way reached by following the pointers from the root
//   next_bits  out  tree bits after touching access_way
module plru_tree import d_cache_pkg::*; #(
  parameter int WAYS = 4,
  localparam int WAY_W = index_width(WAYS)
) (
  input  logic [WAYS-2:0]  bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  next_bits
);

  localparam int LEVELS = $clog2(WAYS);

  // Point every node on the path to 'way' away from it.
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0]  cur,
                                            input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] upd;
    logic            dir;
    int              node;
    upd  = cur;
    node = 0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      dir       = way[LEVELS-1-lvl];
      upd[node] = ~dir;
      node      = 2 * node + 1 + int'(dir);
    end
    return upd;
  endfunction

  // Walk from the root; each visited node bit becomes the next victim bit,
  // most significant first.
  always_comb begin
    int node;
    victim = '0;
    node   = 0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      victim[LEVELS-1-lvl] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
    end
  end

  assign next_bits = touch(bits, access_way);

endmodule

// File: rtl/d_cache_nway.sv
// d_cache_nway
// Write-back, write-allocate, N-way set-associative data cache with
// multi-word lines and tree pseudo-LRU replacement, between the core data
// port and the sram-like lower data port. Uncached requests bypass the arrays.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_data_*                core sram-like request/response port
//   cache_data_*              lower sram-like port, one word per transaction
module d_cache_nway import d_cache_pkg::*; #(
  parameter int INDEX_WIDTH = 6,
  parameter int LINE_WORDS  = 4,
  parameter int WAYS        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  input  logic        cpu_data_uncached,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int OFFSET_W   = $clog2(LINE_WORDS);
  localparam int LINE_SHIFT = OFFSET_W + BYTE_OFFSET_BITS;
  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - LINE_SHIFT;
  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int WAY_W      = index_width(WAYS);
  localparam int CNT_W      = index_width(LINE_WORDS);

  // Control state (reset)
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 outstanding_q;
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];
  logic [WAY_W-1:0]     victim_q;
  logic [TAG_WIDTH-1:0] victim_tag_q;

  // Storage arrays (not reset; guarded by valid)
  logic [TAG_WIDTH-1:0] tag_q  [SETS][WAYS];
  logic [31:0]          data_q [SETS][WAYS][LINE_WORDS];

  // Request decode
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [CNT_W-1:0]       req_word;

  // Lookup results
  logic [WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0] hit_way;
  logic             hit;
  logic             idle_hit;
  logic             idle_miss;
  logic [31:0]      hit_word;
  logic [31:0]      store_mask;
  logic [31:0]      merged_word;

  // Replacement
  logic [WAY_W-1:0] tree_victim;
  logic [WAY_W-1:0] fill_way;
  logic             victim_dirty;
  logic [WAY_W-1:0] access_way;
  logic [WAYS-2:0]  plru_next;

  // Lower-side progress
  logic lower_done;
  logic last_word;

  // Byte address of word k of the line {t, idx}.
  function automatic logic [31:0] line_word_addr(input logic [TAG_WIDTH-1:0]   t,
                                                 input logic [INDEX_WIDTH-1:0] idx,
                                                 input logic [CNT_W-1:0]       k);
    logic [31:0] a;
    a = '0;
    a[31 -: TAG_WIDTH]          = t;
    a[LINE_SHIFT +: INDEX_WIDTH] = idx;
    a = a | (32'(k) << BYTE_OFFSET_BITS);
    return a;
  endfunction

  assign req_tag   = cpu_data_addr[31 -: TAG_WIDTH];
  assign req_index = cpu_data_addr[LINE_SHIFT +: INDEX_WIDTH];
  assign req_word  = CNT_W'((cpu_data_addr >> BYTE_OFFSET_BITS) & 32'(LINE_WORDS - 1));

  // Tag compare across all ways of the indexed set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  assign hit         = (|hit_vec) && !cpu_data_uncached;
  assign idle_hit    = (state_q == IDLE) && cpu_data_req && hit;
  assign idle_miss   = (state_q == IDLE) && cpu_data_req && !hit && !cpu_data_uncached;
  assign hit_word    = data_q[req_index][hit_way][req_word];
  assign store_mask  = expand_mask(byte_mask(cpu_data_size, cpu_data_addr[1:0]));
  assign merged_word = (hit_word & ~store_mask) | (cpu_data_wdata & store_mask);

  // Invalid ways are always preferred over evicting a live line; scanning
  // downwards leaves the lowest-index invalid way selected.
  always_comb begin
    fill_way = tree_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_index][w]) fill_way = WAY_W'(w);
    end
  end

  assign victim_dirty = valid_q[req_index][fill_way] && dirty_q[req_index][fill_way];

  // During refill the tree is touched on behalf of the way being filled;
  // otherwise on behalf of the hitting way.
  assign access_way = (state_q == RF) ? victim_q : hit_way;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits       (plru_q[req_index]),
    .access_way (access_way),
    .victim     (tree_victim),
    .next_bits  (plru_next)
  );

  assign lower_done = cache_data_data_ok && outstanding_q;
  assign last_word  = (cnt_q == CNT_W'(LINE_WORDS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and all port outputs. Lower requests are only raised while
  // nothing is outstanding, giving at most one transaction in flight.
  always_comb begin
    state_d          = state_q;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = '0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'b00;
    cache_data_addr  = '0;
    cache_data_wdata = '0;
    case (state_q)
      IDLE: begin
        if (cpu_data_req) begin
          if (cpu_data_uncached) begin
            state_d = UNC;
          end else if (hit) begin
            cpu_data_addr_ok = 1'b1;
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = hit_word;
          end else if (victim_dirty) begin
            state_d = WB;
          end else begin
            state_d = RF;
          end
        end
      end
      WB: begin
        cache_data_req   = !outstanding_q;
        cache_data_wr    = 1'b1;
        cache_data_size  = SIZE_WORD;
        cache_data_addr  = line_word_addr(victim_tag_q, req_index, cnt_q);
        cache_data_wdata = data_q[req_index][victim_q][cnt_q];
        if (lower_done && last_word) state_d = RF;
      end
      RF: begin
        cache_data_req  = !outstanding_q;
        cache_data_size = SIZE_WORD;
        cache_data_addr = line_word_addr(req_tag, req_index, cnt_q);
        if (lower_done && last_word) state_d = IDLE;
      end
      UNC: begin
        cache_data_req   = !outstanding_q;
        cache_data_wr    = cpu_data_wr;
        cache_data_size  = cpu_data_size;
        cache_data_addr  = cpu_data_addr;
        cache_data_wdata = cpu_data_wdata;
        cpu_data_addr_ok = cache_data_req && cache_data_addr_ok;
        cpu_data_data_ok = lower_done;
        cpu_data_rdata   = cache_data_rdata;
        if (lower_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word counter walks the line during WB and RF and wraps after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (((state_q == WB) || (state_q == RF)) && lower_done) begin
      cnt_q <= last_word ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Outstanding flag: data_ok wins so a same-cycle addr_ok/data_ok pair
  // leaves nothing pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= 1'b0;
    end else if (cache_data_data_ok) begin
      outstanding_q <= 1'b0;
    end else if (cache_data_req && cache_data_addr_ok) begin
      outstanding_q <= 1'b1;
    end
  end

  // Line status and replacement state. The victim is frozen on the miss so
  // WB and RF address the same way even though the set's bits are read live.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      victim_q     <= '0;
      victim_tag_q <= '0;
    end else begin
      if (idle_miss) begin
        victim_q     <= fill_way;
        victim_tag_q <= tag_q[req_index][fill_way];
      end
      if (idle_hit) begin
        plru_q[req_index] <= plru_next;
        if (cpu_data_wr) dirty_q[req_index][hit_way] <= 1'b1;
      end
      if ((state_q == RF) && lower_done && last_word) begin
        valid_q[req_index][victim_q] <= 1'b1;
        dirty_q[req_index][victim_q] <= 1'b0;
        plru_q[req_index]            <= plru_next;
      end
    end
  end

  // Tag and data arrays. Refill words land as they arrive; the line only
  // becomes visible once valid is set after the last word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (idle_hit && cpu_data_wr) begin
        data_q[req_index][hit_way][req_word] <= merged_word;
      end
      if ((state_q == RF) && lower_done) begin
        data_q[req_index][victim_q][cnt_q] <= cache_data_rdata;
        if (last_word) tag_q[req_index][victim_q] <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_d_cache_nway.sv
// tb_d_cache_nway
// Directed self-checking bench for d_cache_nway with default parameters.
// A lower-side responder model accepts one request at a time (addr_ok at one
// negedge, data_ok at the next) backed by a sparse memory whose unwritten
// words read as addr ^ 32'h5A5A_0000, and logs every accepted transaction.
module tb_d_cache_nway;
  import d_cache_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic        cpu_data_uncached;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;

  d_cache_nway dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_data_req       (cpu_data_req),
    .cpu_data_wr        (cpu_data_wr),
    .cpu_data_size      (cpu_data_size),
    .cpu_data_addr      (cpu_data_addr),
    .cpu_data_wdata     (cpu_data_wdata),
    .cpu_data_uncached  (cpu_data_uncached),
    .cpu_data_rdata     (cpu_data_rdata),
    .cpu_data_addr_ok   (cpu_data_addr_ok),
    .cpu_data_data_ok   (cpu_data_data_ok),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int dataOkCount = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] logAddr[$];
  logic        logWr[$];
  logic [1:0]  logSize[$];
  logic [31:0] logWdata[$];
  bit          pending;
  logic [31:0] pendData;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic clearLog();
    logAddr.delete();
    logWr.delete();
    logSize.delete();
    logWdata.delete();
  endtask

  // Compare logged lower transaction idx against the expected address/kind.
  task automatic checkTxn(input string tag, input int idx, input logic [31:0] addr,
                          input logic wr, input logic [1:0] size);
    if (idx < logAddr.size()) begin
      checkOutput({tag, "_addr"}, logAddr[idx], addr);
      checkOutput({tag, "_wr"}, 32'(logWr[idx]), 32'(wr));
      checkOutput({tag, "_size"}, 32'(logSize[idx]), 32'(size));
    end else begin
      checkOutput({tag, "_present"}, 32'(logAddr.size()), 32'(idx + 1));
    end
  endtask

  // Lower-side responder.
  initial begin
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = '0;
    pending            = 1'b0;
    pendData           = '0;
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (pending) begin
        cache_data_data_ok = 1'b1;
        cache_data_rdata   = pendData;
        pending            = 1'b0;
        dataOkCount++;
      end else if (cache_data_req) begin
        cache_data_addr_ok = 1'b1;
        logAddr.push_back(cache_data_addr);
        logWr.push_back(cache_data_wr);
        logSize.push_back(cache_data_size);
        logWdata.push_back(cache_data_wdata);
        if (cache_data_wr) begin
          mem[cache_data_addr] = cache_data_wdata;
          pendData = '0;
        end else begin
          pendData = memRead(cache_data_addr);
        end
        pending = 1'b1;
      end
    end
  end

  // One core access: hold the request until addr_ok, then wait for data_ok.
  // cycles counts sampled cycles from request to data_ok inclusive.
  task automatic applyStimulus(input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic unc, output logic [31:0] rdata,
                               output int cycles);
    bit gotAddr;
    bit gotData;
    gotAddr = 1'b0;
    gotData = 1'b0;
    cycles  = 0;
    rdata   = '0;
    @(posedge clk); #1;
    cpu_data_req      = 1'b1;
    cpu_data_wr       = wr;
    cpu_data_size     = size;
    cpu_data_addr     = addr;
    cpu_data_wdata    = wdata;
    cpu_data_uncached = unc;
    while (!gotData && cycles < 200) begin
      @(negedge clk); #2;
      cycles++;
      if (!gotAddr && cpu_data_addr_ok) gotAddr = 1'b1;
      if (gotAddr && cpu_data_data_ok) begin
        gotData = 1'b1;
        rdata   = cpu_data_rdata;
      end
      @(posedge clk); #1;
      if (gotAddr) cpu_data_req = 1'b0;
    end
    cpu_data_req = 1'b0;
    checkOutput("access_done", 32'(gotData), 32'd1);
  endtask

  task automatic load(input logic [31:0] addr, output logic [31:0] rdata, output int cycles);
    applyStimulus(1'b0, SIZE_WORD, addr, 32'h0, 1'b0, rdata, cycles);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          base;
    bit          reached;

    rst               = 1'b1;
    cpu_data_req      = 1'b0;
    cpu_data_wr       = 1'b0;
    cpu_data_size     = 2'b00;
    cpu_data_addr     = '0;
    cpu_data_wdata    = '0;
    cpu_data_uncached = 1'b0;
    mem[32'h0000_1040] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk); #2;
    checkOutput("rst_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
    checkOutput("rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
    checkOutput("rst_rdata", cpu_data_rdata, 32'd0);
    checkOutput("rst_lower_req", 32'(cache_data_req), 32'd0);
    checkOutput("rst_lower_wr", 32'(cache_data_wr), 32'd0);
    checkOutput("rst_lower_size", 32'(cache_data_size), 32'd0);
    checkOutput("rst_lower_addr", cache_data_addr, 32'd0);
    checkOutput("rst_lower_wdata", cache_data_wdata, 32'd0);

    // 1: cold load, 4-word refill, then a hit in the request cycle
    clearLog();
    load(32'h0000_1040, rd, cyc);
    checkOutput("t1_rdata", rd, 32'h1122_3344);
    checkOutput("t1_latency", 32'(cyc), 32'd10);
    checkOutput("t1_txn_count", 32'(logAddr.size()), 32'd4);
    for (int k = 0; k < 4; k++) checkTxn("t1_rf", k, 32'h0000_1040 + 32'(4 * k), 1'b0, SIZE_WORD);
    clearLog();
    load(32'h0000_104C, rd, cyc);
    checkOutput("t1_hit_rdata", rd, 32'h5A5A_104C);
    checkOutput("t1_hit_cycles", 32'(cyc), 32'd1);
    checkOutput("t1_hit_no_lower", 32'(logAddr.size()), 32'd0);

    // 2: byte store hit merges into the resident word
    clearLog();
    applyStimulus(1'b1, SIZE_BYTE, 32'h0000_1041, 32'h0000_AB00, 1'b0, rd, cyc);
    checkOutput("t2_sb_cycles", 32'(cyc), 32'd1);
    checkOutput("t2_sb_no_lower", 32'(logAddr.size()), 32'd0);
    load(32'h0000_1040, rd, cyc);
    checkOutput("t2_merged", rd, 32'h1122_AB44);

    // 2b: fill the rest of set 4; the next miss must write the dirty line back
    load(32'h0000_0040, rd, cyc);
    load(32'h0000_0440, rd, cyc);
    load(32'h0000_0840, rd, cyc);
    clearLog();
    load(32'h0000_0C40, rd, cyc);
    checkOutput("t2b_rdata", rd, 32'h5A5A_0C40);
    checkOutput("t2b_txn_count", 32'(logAddr.size()), 32'd8);
    checkTxn("t2b_wb0", 0, 32'h0000_1040, 1'b1, SIZE_WORD);
    checkOutput("t2b_wb0_data", logWdata.size() > 0 ? logWdata[0] : 32'h0, 32'h1122_AB44);
    checkTxn("t2b_wb3", 3, 32'h0000_104C, 1'b1, SIZE_WORD);
    checkTxn("t2b_rf0", 4, 32'h0000_0C40, 1'b0, SIZE_WORD);

    // 3: fresh set 4, dirty 0x0040 becomes LRU after touching the others
    pulseReset();
    load(32'h0000_0040, rd, cyc);
    load(32'h0000_0440, rd, cyc);
    load(32'h0000_0840, rd, cyc);
    load(32'h0000_0C40, rd, cyc);
    applyStimulus(1'b1, SIZE_WORD, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, rd, cyc);
    clearLog();
    load(32'h0000_0440, rd, cyc);
    load(32'h0000_0840, rd, cyc);
    load(32'h0000_0C40, rd, cyc);
    checkOutput("t3_touch_hits", 32'(logAddr.size()), 32'd0);
    load(32'h0000_1040, rd, cyc);
    checkOutput("t3_rdata", rd, 32'h1122_AB44);
    checkOutput("t3_latency", 32'(cyc), 32'd18);
    checkOutput("t3_txn_count", 32'(logAddr.size()), 32'd8);
    checkTxn("t3_wb0", 0, 32'h0000_0040, 1'b1, SIZE_WORD);
    checkOutput("t3_wb0_data", logWdata.size() > 0 ? logWdata[0] : 32'h0, 32'hCAFE_F00D);
    checkOutput("t3_wb1_data", logWdata.size() > 1 ? logWdata[1] : 32'h0, 32'h5A5A_0044);
    checkTxn("t3_wb3", 3, 32'h0000_004C, 1'b1, SIZE_WORD);
    checkTxn("t3_rf0", 4, 32'h0000_1040, 1'b0, SIZE_WORD);
    checkTxn("t3_rf3", 7, 32'h0000_104C, 1'b0, SIZE_WORD);

    // 4: hits to ways 0,1,2,3,0 of set 5, then a miss replaces way 2
    load(32'h0000_0050, rd, cyc);
    load(32'h0000_0450, rd, cyc);
    load(32'h0000_0850, rd, cyc);
    load(32'h0000_0C50, rd, cyc);
    clearLog();
    load(32'h0000_0050, rd, cyc);
    load(32'h0000_0450, rd, cyc);
    load(32'h0000_0850, rd, cyc);
    load(32'h0000_0C50, rd, cyc);
    load(32'h0000_0050, rd, cyc);
    checkOutput("t4_hits_no_lower", 32'(logAddr.size()), 32'd0);
    load(32'h0000_1050, rd, cyc);
    checkOutput("t4_miss_rdata", rd, 32'h5A5A_1050);
    checkOutput("t4_miss_txn_count", 32'(logAddr.size()), 32'd4);
    checkTxn("t4_rf0", 0, 32'h0000_1050, 1'b0, SIZE_WORD);
    clearLog();
    load(32'h0000_0050, rd, cyc);
    load(32'h0000_0450, rd, cyc);
    load(32'h0000_0C50, rd, cyc);
    checkOutput("t4_survivors_hit", 32'(logAddr.size()), 32'd0);
    load(32'h0000_0850, rd, cyc);
    checkOutput("t4_way2_evicted", 32'(logAddr.size()), 32'd4);

    // 5: uncached byte load passes straight through, every time
    clearLog();
    applyStimulus(1'b0, SIZE_BYTE, 32'hBFC0_0000, 32'h0, 1'b1, rd, cyc);
    checkOutput("t5_txn_count", 32'(logAddr.size()), 32'd1);
    checkTxn("t5_unc", 0, 32'hBFC0_0000, 1'b0, SIZE_BYTE);
    checkOutput("t5_rdata", rd, 32'hE59A_0000);
    clearLog();
    applyStimulus(1'b0, SIZE_BYTE, 32'hBFC0_0000, 32'h0, 1'b1, rd, cyc);
    checkOutput("t5_repeat_txn_count", 32'(logAddr.size()), 32'd1);
    checkOutput("t5_repeat_rdata", rd, 32'hE59A_0000);

    // 6: reset after two of four refill words
    clearLog();
    base    = dataOkCount;
    reached = 1'b0;
    @(posedge clk); #1;
    cpu_data_req      = 1'b1;
    cpu_data_wr       = 1'b0;
    cpu_data_size     = SIZE_WORD;
    cpu_data_addr     = 32'h0000_2060;
    cpu_data_wdata    = 32'h0;
    cpu_data_uncached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge clk); #2;
      if (dataOkCount >= base + 2) reached = 1'b1;
    end
    checkOutput("t6_two_words", 32'(reached), 32'd1);
    @(posedge clk); #1;
    rst          = 1'b1;
    cpu_data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #2;
    checkOutput("t6_lower_req", 32'(cache_data_req), 32'd0);
    checkOutput("t6_lower_addr", cache_data_addr, 32'd0);
    checkOutput("t6_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
    checkOutput("t6_data_ok", 32'(cpu_data_data_ok), 32'd0);
    clearLog();
    load(32'h0000_2060, rd, cyc);
    checkOutput("t6_refill_count", 32'(logAddr.size()), 32'd4);
    checkTxn("t6_rf0", 0, 32'h0000_2060, 1'b0, SIZE_WORD);
    checkTxn("t6_rf3", 3, 32'h0000_206C, 1'b0, SIZE_WORD);
    checkOutput("t6_rdata", rd, 32'h5A5A_2060);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
